// File: rtl/tm1638_rx_pkg.sv
// Shared types and constants for the TM1638 receive slave.
package tm1638_rx_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    IGNORE = 2'd3
  } rx_state_t;

  // Command class lives in bits 7:6 of the first byte of a frame.
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_DISP = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int RAM_DEPTH = 16;

endpackage

// File: rtl/tm1638_rx_shifter.sv
// Synchronizes STB/CLK/DIO, detects edges and assembles LSB-first bytes.
// All outputs are registered and mutually aligned: a byte completed on the
// same synced cycle as the STB rise is reported together with stb_rise, and
// partial then reads 0.
module tm1638_rx_shifter
  import tm1638_rx_types::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_stb,
  input  logic       spi_clk,
  input  logic       spi_dio,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       partial,
  output logic       stb_fall,
  output logic       stb_rise
);

  logic [SYNC_STAGES-1:0] stb_sync, clk_sync, dio_sync;
  logic stb_q, stb_q2, clk_q, clk_q2, dio_q;
  logic in_frame;
  logic [2:0] bit_cnt;
  logic [7:0] shift;
  logic clk_rise, shift_en;
  logic [2:0] next_cnt;
  logic [7:0] next_shift;

  // Edge detection and next-bit computation from the registered synced copies.
  always_comb begin
    clk_rise   = clk_q & ~clk_q2;
    shift_en   = clk_rise & in_frame;
    next_cnt   = shift_en ? bit_cnt + 3'd1 : bit_cnt;
    next_shift = {dio_q, shift[7:1]};
  end

  // Identical-depth synchronizers plus one register stage for edge detection.
  // STB resets low so a strobe already low at reset release never looks like
  // a frame start; the frame begins only after STB goes high and low again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_sync <= '0;
      clk_sync <= '1;
      dio_sync <= '0;
      stb_q    <= 1'b0;
      stb_q2   <= 1'b0;
      clk_q    <= 1'b1;
      clk_q2   <= 1'b1;
      dio_q    <= 1'b0;
    end else begin
      stb_sync[0] <= spi_stb;
      clk_sync[0] <= spi_clk;
      dio_sync[0] <= spi_dio;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stb_sync[i] <= stb_sync[i-1];
        clk_sync[i] <= clk_sync[i-1];
        dio_sync[i] <= dio_sync[i-1];
      end
      stb_q  <= stb_sync[SYNC_STAGES-1];
      clk_q  <= clk_sync[SYNC_STAGES-1];
      dio_q  <= dio_sync[SYNC_STAGES-1];
      stb_q2 <= stb_q;
      clk_q2 <= clk_q;
    end
  end

  // Bit counter and shift register, active only inside a strobe-low frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_frame   <= 1'b0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      partial    <= 1'b0;
      stb_fall   <= 1'b0;
      stb_rise   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      partial    <= 1'b0;
      stb_fall   <= stb_q2 & ~stb_q;
      stb_rise   <= ~stb_q2 & stb_q;
      if (shift_en) begin
        shift <= next_shift;
        if (bit_cnt == 3'd7) begin
          rx_byte    <= next_shift;
          byte_valid <= 1'b1;
        end
      end
      if (stb_q2 & ~stb_q) begin
        in_frame <= 1'b1;
        bit_cnt  <= 3'd0;
      end else if (~stb_q2 & stb_q) begin
        in_frame <= 1'b0;
        bit_cnt  <= 3'd0;
        partial  <= (next_cnt != 3'd0);
      end else begin
        bit_cnt <= next_cnt;
      end
    end
  end

endmodule

// File: rtl/tm1638_rx.sv
// TM1638-compatible receive slave: command decode, display RAM and state.
// Output pulses (o_Byte_Valid, o_Ram_We, o_Frame_Error) are single-cycle
// strobes with no back-pressure; companion data (o_Byte, o_Ram_Addr) is
// valid in the pulse cycle and holds until the next pulse.
module tm1638_rx
  import tm1638_rx_types::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_SPI_Stb,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_Dio,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic [7:0] o_Byte,
  output logic       o_Byte_Valid,
  output logic       o_Ram_We,
  output logic [3:0] o_Ram_Addr,
  output logic       o_Display_On,
  output logic [2:0] o_Brightness,
  output logic       o_Frame_Error,
  output rx_state_t  o_Diag_State
);

  logic [7:0] sh_byte;
  logic sh_valid, sh_partial, sh_fall, sh_rise;

  rx_state_t  state;
  logic [7:0] ram [RAM_DEPTH];
  logic       auto_inc;
  logic [3:0] addr;

  assign o_Diag_State = state;

  tm1638_rx_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .spi_stb    (i_SPI_Stb),
    .spi_clk    (i_SPI_Clk),
    .spi_dio    (i_SPI_Dio),
    .rx_byte    (sh_byte),
    .byte_valid (sh_valid),
    .partial    (sh_partial),
    .stb_fall   (sh_fall),
    .stb_rise   (sh_rise)
  );

  // Frame FSM: decode the command byte, write data bytes, flag violations.
  // A byte landing together with the STB rise is handled before returning
  // to IDLE, because the later state assignment below overrides the case.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state         <= IDLE;
      auto_inc      <= 1'b1;
      addr          <= 4'd0;
      o_Byte        <= 8'h00;
      o_Byte_Valid  <= 1'b0;
      o_Ram_We      <= 1'b0;
      o_Ram_Addr    <= 4'd0;
      o_Display_On  <= 1'b0;
      o_Brightness  <= 3'd0;
      o_Frame_Error <= 1'b0;
      for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= 8'h00;
    end else begin
      o_Byte_Valid  <= 1'b0;
      o_Ram_We      <= 1'b0;
      o_Frame_Error <= 1'b0;
      if (sh_valid && state != IDLE) begin
        o_Byte       <= sh_byte;
        o_Byte_Valid <= 1'b1;
      end
      case (state)
        IDLE: if (sh_fall) state <= CMD;
        CMD: if (sh_valid) begin
          state <= IGNORE;
          case (sh_byte[7:6])
            CMD_DATA: begin
              if (sh_byte[1]) o_Frame_Error <= 1'b1;
              else auto_inc <= ~sh_byte[2];
            end
            CMD_DISP: begin
              o_Display_On <= sh_byte[3];
              o_Brightness <= sh_byte[2:0];
            end
            CMD_ADDR: begin
              addr  <= sh_byte[3:0];
              state <= DATA;
            end
            default: o_Frame_Error <= 1'b1;
          endcase
        end
        DATA: if (sh_valid) begin
          ram[addr]  <= sh_byte;
          o_Ram_We   <= 1'b1;
          o_Ram_Addr <= addr;
          if (auto_inc) addr <= addr + 4'd1;
        end
        IGNORE: if (sh_valid) o_Frame_Error <= 1'b1;
        default: state <= IDLE;
      endcase
      if (sh_rise) begin
        state <= IDLE;
        if (sh_partial) o_Frame_Error <= 1'b1;
      end
    end
  end

  // Registered read port into the display RAM image.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) o_Rd_Data <= 8'h00;
    else       o_Rd_Data <= ram[i_Rd_Addr];
  end

endmodule

// File: tb/tb_tm1638_rx.sv
// Bench for tm1638_rx: frame-level reference model, per-cycle compare process.
module tb_tm1638_rx;
  import tm1638_rx_types::*;

  localparam int S = 2;

  logic clk, rst;
  logic spi_stb, spi_clk, spi_dio;
  logic [3:0] rd_addr;
  logic [7:0] o_rd_data, o_byte;
  logic o_byte_valid, o_ram_we, o_display_on, o_frame_error;
  logic [3:0] o_ram_addr;
  logic [2:0] o_brightness;
  rx_state_t o_diag_state;

  tm1638_rx #(.SYNC_STAGES(S)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_SPI_Stb(spi_stb), .i_SPI_Clk(spi_clk),
    .i_SPI_Dio(spi_dio), .i_Rd_Addr(rd_addr), .o_Rd_Data(o_rd_data),
    .o_Byte(o_byte), .o_Byte_Valid(o_byte_valid), .o_Ram_We(o_ram_we),
    .o_Ram_Addr(o_ram_addr), .o_Display_On(o_display_on),
    .o_Brightness(o_brightness), .o_Frame_Error(o_frame_error),
    .o_Diag_State(o_diag_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model state ----------------
  logic [7:0]  m_ram [16];
  bit          m_auto_inc, m_disp_on, m_first, m_data_mode, m_pending_partial;
  logic [2:0]  m_bright;
  logic [3:0]  m_addr;
  int          exp_err;
  logic [7:0]  exp_byte_q[$];
  logic [11:0] exp_wr_q[$];
  int          eighth_cyc;
  bit          run;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
    m_auto_inc = 1; m_disp_on = 0; m_bright = 3'd0; m_addr = 4'd0;
    m_first = 1; m_data_mode = 0; m_pending_partial = 0; exp_err = 0;
    exp_byte_q.delete();
    exp_wr_q.delete();
  endtask

  // Apply the protocol rules to one complete byte of the current frame.
  task automatic model_byte(input logic [7:0] b);
    exp_byte_q.push_back(b);
    if (m_first) begin
      m_first = 0;
      m_data_mode = 0;
      case (b[7:6])
        2'b01: if (b[1]) exp_err++; else m_auto_inc = !b[2];
        2'b10: begin m_disp_on = b[3]; m_bright = b[2:0]; end
        2'b11: begin m_addr = b[3:0]; m_data_mode = 1; end
        default: exp_err++;
      endcase
    end else if (m_data_mode) begin
      exp_wr_q.push_back({m_addr, b});
      m_ram[m_addr] = b;
      if (m_auto_inc) m_addr = m_addr + 4'd1;
    end else begin
      exp_err++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic half();
    tick($urandom_range(1, 3));
  endtask

  task automatic frame_begin();
    spi_stb = 1'b0;
    m_first = 1;
    m_data_mode = 0;
    half();
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input bit use_model, input bit stb_last);
    if (use_model) begin
      if (nbits == 8) model_byte(b);
      else m_pending_partial = 1;
    end
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      spi_dio = b[i];
      half();
      spi_clk = 1'b1;
      if (i == 7) eighth_cyc = cyc + 1;
      if (stb_last && i == nbits - 1) spi_stb = 1'b1;
      half();
    end
  endtask

  task automatic frame_end(input bit already_high);
    if (m_pending_partial) exp_err++;
    m_pending_partial = 0;
    if (!already_high) begin
      half();
      spi_stb = 1'b1;
    end
    tick(S + 6);
    check("byte_q_drained", exp_byte_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("errors_pending", exp_err, 0);
    check("display_on", o_display_on, m_disp_on);
    check("brightness", o_brightness, m_bright);
    check("state_idle", o_diag_state, IDLE);
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    frame_begin();
    foreach (bytes[i]) send_bits(bytes[i], 8, 1, 0);
    frame_end(0);
  endtask

  task automatic read_ram(input logic [3:0] a, output logic [7:0] d);
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
    d = o_rd_data;
  endtask

  task automatic check_ram();
    logic [7:0] d;
    for (int a = 0; a < 16; a++) begin
      read_ram(4'(a), d);
      check("ram_image", d, m_ram[a]);
    end
    #1;
  endtask

  task automatic check_resets(input string tag);
    check({tag, "_byte"}, o_byte, 8'h00);
    check({tag, "_byte_valid"}, o_byte_valid, 0);
    check({tag, "_ram_we"}, o_ram_we, 0);
    check({tag, "_frame_error"}, o_frame_error, 0);
    check({tag, "_display_on"}, o_display_on, 0);
    check({tag, "_brightness"}, o_brightness, 0);
    check({tag, "_state"}, o_diag_state, IDLE);
    check({tag, "_rd_data"}, o_rd_data, 8'h00);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    if (run && !rst) begin
      if (o_byte_valid) begin
        check("byte_expected", exp_byte_q.size() > 0, 1);
        if (exp_byte_q.size() > 0) begin
          check("byte_value", o_byte, exp_byte_q.pop_front());
          check("byte_latency", cyc - eighth_cyc, S + 2);
        end
      end
      if (o_ram_we) begin
        check("write_expected", exp_wr_q.size() > 0, 1);
        if (exp_wr_q.size() > 0) check("write_addr_data", {o_ram_addr, o_byte}, exp_wr_q.pop_front());
      end
      if (o_frame_error) begin
        check("error_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  // ---------------- random frames ----------------
  task automatic random_frame();
    int r, nd, pbits;
    logic [7:0] cmd;
    bit with_last;
    r = $urandom_range(0, 9);
    case (r)
      4, 5: begin
        cmd = {2'b01, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1))};
        nd = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      6: begin
        cmd = {2'b10, 6'($urandom_range(0, 63))};
        nd = ($urandom_range(0, 3) == 0) ? 1 : 0;
      end
      7: begin
        cmd = {2'b00, 6'($urandom_range(0, 63))};
        nd = $urandom_range(0, 1);
      end
      8: begin
        cmd = {2'b01, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1))};
        nd = $urandom_range(0, 1);
      end
      default: begin
        cmd = {2'b11, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        nd = $urandom_range(0, 6);
      end
    endcase
    pbits = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
    with_last = (pbits == 0) && ($urandom_range(0, 4) == 0);
    frame_begin();
    send_bits(cmd, 8, 1, with_last && nd == 0);
    for (int i = 0; i < nd; i++) send_bits(8'($urandom_range(0, 255)), 8, 1, with_last && i == nd - 1);
    if (pbits > 0) send_bits(8'($urandom_range(0, 255)), pbits, 1, 0);
    frame_end(with_last);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #5ms;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] seq[$];
    rst = 1'b1; spi_stb = 1'b1; spi_clk = 1'b1; spi_dio = 1'b0; rd_addr = 4'd0;
    run = 0; eighth_cyc = 0;
    model_reset();
    tick(3);
    check_resets("reset");
    rst = 1'b0;
    tick(S + 4);
    run = 1;

    // Write three digits with auto-increment, then display on at full brightness.
    send_frame('{8'h40});
    send_frame('{8'hC0, 8'h3F, 8'h06, 8'h5B});
    send_frame('{8'h8F});
    read_ram(4'd0, d); check("lit_ram0", d, 8'h3F);
    read_ram(4'd1, d); check("lit_ram1", d, 8'h06);
    read_ram(4'd2, d); check("lit_ram2", d, 8'h5B);
    #1;
    check("lit_display_on", o_display_on, 1);
    check("lit_brightness", o_brightness, 3'd7);
    check_ram();

    // Fixed address mode: both data bytes land on address 5.
    send_frame('{8'h44});
    send_frame('{8'hC5, 8'hAA, 8'h55});
    read_ram(4'd5, d); check("lit_ram5_fixed", d, 8'h55);
    #1;

    // Auto-increment wraps 15 -> 0 over 17 data bytes.
    send_frame('{8'h40});
    seq = '{8'hC0};
    for (int i = 0; i <= 16; i++) seq.push_back(8'(i));
    send_frame(seq);
    read_ram(4'd0, d);  check("lit_ram0_wrap", d, 8'h10);
    read_ram(4'd1, d);  check("lit_ram1_wrap", d, 8'h01);
    read_ram(4'd15, d); check("lit_ram15_wrap", d, 8'h0F);
    #1;
    check_ram();

    // Strobe raised after 5 bits of a data byte, then a normal frame.
    frame_begin();
    send_bits(8'hC3, 8, 1, 0);
    send_bits(8'hEE, 5, 1, 0);
    frame_end(0);
    send_frame('{8'hC4, 8'h7E});
    check_ram();

    // Read command, invalid command, data command with an extra byte.
    frame_begin();
    send_bits(8'h42, 8, 1, 0);
    tick(S + 4);
    check("state_ignore_after_read", o_diag_state, IGNORE);
    frame_end(0);
    send_frame('{8'h00});
    send_frame('{8'h40, 8'h12});
    check_ram();

    // STB rise coincident with the 8th CLK rise of the last data byte.
    frame_begin();
    send_bits(8'hC9, 8, 1, 0);
    send_bits(8'hA5, 8, 1, 1);
    frame_end(1);
    check_ram();

    // Randomized frames against the model.
    for (int n = 0; n < 40; n++) random_frame();
    check_ram();

    // Reset in the middle of a data byte; leftover bytes before STB high
    // must be ignored and all state returns to reset values.
    send_frame('{8'h44});
    send_frame('{8'hC0, 8'h3C});
    frame_begin();
    send_bits(8'hC2, 8, 1, 0);
    send_bits(8'h5A, 8, 1, 0);
    send_bits(8'h33, 4, 0, 0);
    run = 0;
    rst = 1'b1;
    model_reset();
    tick(1);
    check_resets("mid_reset");
    rst = 1'b0;
    tick(1);
    check_resets("post_reset");
    run = 1;
    send_bits(8'h0F, 4, 0, 0);
    send_bits(8'hC7, 8, 0, 0);
    send_bits(8'h99, 8, 0, 0);
    frame_end(0);
    check_ram();
    // Auto-increment is back on after reset.
    send_frame('{8'hC0, 8'hA1, 8'hB2});
    read_ram(4'd1, d); check("lit_ram1_after_reset", d, 8'hB2);
    #1;
    check_ram();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
